// File: rtl/asic_iopoc_pkg.sv
// rtl/asic_iopoc_pkg.sv - shared state encoding for the padring POC sequencer
package asic_iopoc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_PWR = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

endpackage

// File: rtl/asic_iopoc_sync.sv
// rtl/asic_iopoc_sync.sv - multi-stage synchronizer for an asynchronous supply flag
module asic_iopoc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/asic_iopoc_ctrl.sv
// rtl/asic_iopoc_ctrl.sv - padring power-on-control sequencer driving the shared poc net
module asic_iopoc_ctrl
    import asic_iopoc_pkg::*;
#(
    parameter int SYNC    = 2,
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               en,
    input  logic               vdd_ok,
    input  logic               vddio_ok,
    input  logic               clr_fault,
    output logic               poc,
    output logic               io_ready,
    output logic               fault,
    output logic [STATE_W-1:0] state
);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam bit            TIMEOUT_EN   = (TIMEOUT != 0);

    logic               vdd_s;
    logic               vddio_s;
    logic               ok_s;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;

    asic_iopoc_sync #(.STAGES(SYNC)) u_sync_vdd (
        .clk   (clk),
        .rst_n (nreset),
        .d     (vdd_ok),
        .q     (vdd_s)
    );

    asic_iopoc_sync #(.STAGES(SYNC)) u_sync_vddio (
        .clk   (clk),
        .rst_n (nreset),
        .d     (vddio_ok),
        .q     (vddio_s)
    );

    assign ok_s = vdd_s & vddio_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (en) state_d = ST_WAIT_PWR;
            end
            ST_WAIT_PWR: begin
                if (!en)                                    state_d = ST_OFF;
                else if (ok_s)                              state_d = ST_SETTLE;
                else if (TIMEOUT_EN && cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
                else                                        cnt_d   = cnt_q + CW'(1);
            end
            ST_SETTLE: begin
                if (!en)                        state_d = ST_OFF;
                else if (!ok_s)                 state_d = ST_WAIT_PWR;
                else if (cnt_q == SETTLE_LAST)  state_d = ST_ACTIVE;
                else                            cnt_d   = cnt_q + CW'(1);
            end
            ST_ACTIVE: begin
                // Losing a supply while the IOs are live is a fault even if software is shutting down.
                if (!ok_s)    state_d = ST_FAULT;
                else if (!en) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_OFF;
                else                      cnt_d   = cnt_q + CW'(1);
            end
            ST_FAULT: begin
                if (clr_fault && !en) state_d = ST_OFF;
            end
            default: state_d = ST_FAULT;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            poc      <= 1'b1;
            io_ready <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            poc      <= (state_d != ST_ACTIVE);
            io_ready <= (state_d == ST_ACTIVE);
            fault    <= (state_d == ST_FAULT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_asic_iopoc_ctrl.sv
// tb/tb_asic_iopoc_ctrl.sv - directed self-checking bench for asic_iopoc_ctrl
module tb_asic_iopoc_ctrl;

    logic       clk = 1'b0;
    logic       nreset;
    logic       en;
    logic       vdd_ok;
    logic       vddio_ok;
    logic       clr_fault;
    logic       poc;
    logic       io_ready;
    logic       fault;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    asic_iopoc_ctrl #(.SYNC(2), .SETTLE(4), .TIMEOUT(16), .CW(16)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .en        (en),
        .vdd_ok    (vdd_ok),
        .vddio_ok  (vddio_ok),
        .clr_fault (clr_fault),
        .poc       (poc),
        .io_ready  (io_ready),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic p,
                              input logic rdy, input logic flt);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".poc"}, 32'(poc), 32'(p));
        check({tag, ".io_ready"}, 32'(io_ready), 32'(rdy));
        check({tag, ".fault"}, 32'(fault), 32'(flt));
    endtask

    initial begin
        nreset = 1'b0; en = 1'b0; vdd_ok = 1'b0; vddio_ok = 1'b0; clr_fault = 1'b0;
        tick(3);
        check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0);
        nreset = 1'b1;
        tick(2);
        check_outs("idle", 3'd0, 1'b1, 1'b0, 1'b0);

        // Nominal power-up: supplies rise at cycle t, SETTLE at t+3, ACTIVE at t+7
        en = 1'b1;
        tick(1);
        check("nom.wait", 32'(state), 32'd1);
        vdd_ok = 1'b1; vddio_ok = 1'b1;
        tick(2);
        check("nom.still_wait", 32'(state), 32'd1);
        tick(1);
        check_outs("nom.settle", 3'd2, 1'b1, 1'b0, 1'b0);
        tick(3);
        check_outs("nom.settle_end", 3'd2, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("nom.active", 3'd3, 1'b0, 1'b1, 1'b0);

        // Orderly release with en bouncing high during RELEASE
        en = 1'b0;
        tick(1);
        check_outs("rel.entry", 3'd4, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        tick(3);
        check("rel.hold", 32'(state), 32'd4);
        tick(1);
        check_outs("rel.off", 3'd0, 1'b1, 1'b0, 1'b0);
        tick(1);
        check("rel.rewait", 32'(state), 32'd1);
        tick(1);
        check("rel.resettle", 32'(state), 32'd2);
        tick(4);
        check("rel.reactive", 32'(state), 32'd3);

        // Supply loss in ACTIVE, en dropped on the cycle the loss reaches the FSM
        vddio_ok = 1'b0;
        tick(2);
        check_outs("loss.pending", 3'd3, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        tick(1);
        check_outs("loss.fault", 3'd5, 1'b1, 1'b0, 1'b1);
        clr_fault = 1'b1;
        tick(1);
        check_outs("loss.clr", 3'd0, 1'b1, 1'b0, 1'b0);
        clr_fault = 1'b0;

        // Timeout with vddio held low: FAULT exactly 16 cycles after WAIT_PWR entry
        en = 1'b1;
        tick(1);
        check("to.wait", 32'(state), 32'd1);
        tick(15);
        check_outs("to.last_wait", 3'd1, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("to.fault", 3'd5, 1'b1, 1'b0, 1'b1);
        clr_fault = 1'b1;
        tick(2);
        check("to.clr_blocked", 32'(state), 32'd5);
        en = 1'b0;
        tick(1);
        check_outs("to.cleared", 3'd0, 1'b1, 1'b0, 1'b0);
        clr_fault = 1'b0;

        // Settle abort: ok_s falls at settle count 2, full settle restarts after return
        vddio_ok = 1'b1;
        tick(3);
        en = 1'b1;
        tick(1);
        check("ab.wait", 32'(state), 32'd1);
        tick(1);
        check("ab.settle", 32'(state), 32'd2);
        vdd_ok = 1'b0;
        tick(2);
        check("ab.settle_cnt2", 32'(state), 32'd2);
        tick(1);
        check_outs("ab.back_wait", 3'd1, 1'b1, 1'b0, 1'b0);
        vdd_ok = 1'b1;
        tick(2);
        check("ab.wait_sync", 32'(state), 32'd1);
        tick(1);
        check("ab.resettle", 32'(state), 32'd2);
        tick(3);
        check_outs("ab.settle_full", 3'd2, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("ab.active", 3'd3, 1'b0, 1'b1, 1'b0);

        // Async reset mid-ACTIVE, no clock edge in between
        #2 nreset = 1'b0;
        #1 check_outs("ar.active", 3'd0, 1'b1, 1'b0, 1'b0);
        #2 nreset = 1'b1;
        tick(1);
        check("ar.restart_wait", 32'(state), 32'd1);
        tick(1);
        check("ar.sync_refill", 32'(state), 32'd1);
        tick(1);
        check("ar.settle", 32'(state), 32'd2);

        // Async reset mid-SETTLE
        tick(1);
        #2 nreset = 1'b0;
        #1 check_outs("ar.settle_rst", 3'd0, 1'b1, 1'b0, 1'b0);
        #2 nreset = 1'b1;
        tick(1);
        check("ar.settle_restart", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
